tx_iod_lane_training_gen: RTL and testbench



---
 rtl/tx_iod_lane_training_gen.sv | 137 +++++++++++++
 tb/tb_tx_iod_lane_training_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_iod_lane_training_gen.sv
// Transmit lane controller for DDRX4 TX IODs: training pattern, sync word,
// then valid/ready payload, identical sequencing on every lane.
module tx_iod_lane_training_gen #(
    parameter int          LANES            = 2,
    parameter int          PATTERN_SEL      = 0,
    parameter logic [7:0]  TRAIN_WORD       = 8'hF0,
    parameter logic [7:0]  SYNC_WORD        = 8'hB5,
    parameter logic [7:0]  IDLE_WORD        = 8'h3C,
    parameter int          TRAIN_MIN_CYCLES = 256,
    parameter int          SYNC_CYCLES      = 2
) (
    input  logic               FAB_CLK,
    input  logic               TX_SYNC_RST,
    input  logic               TRAIN_REQ,
    input  logic               ALIGN_DONE,
    input  logic [8*LANES-1:0] TX_IN_DATA,
    input  logic               TX_IN_VALID,
    output logic               TX_IN_READY,
    output logic [8*LANES-1:0] TX_DATA,
    output logic [1:0]         TX_STATE,
    output logic               TRAINING
);

    localparam int MAXC = (TRAIN_MIN_CYCLES > SYNC_CYCLES) ?
                          TRAIN_MIN_CYCLES : SYNC_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_MIN_CYCLES - 1);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_CYCLES - 1);
    localparam logic [6:0]    PRBS_SEED  = 7'h7F;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [6:0]         r_prbs;
    logic [6:0]         w_prbs_nxt;
    logic [6:0]         w_prbs_step;
    logic [7:0]         w_prbs_word;
    logic [7:0]         w_train_word;
    logic [8*LANES-1:0] w_data_nxt;
    logic [8*LANES-1:0] r_tx_data;
    logic [1:0]         r_tx_state;
    logic               r_training;

    // Eight LFSR steps per word; bit 0 is the first bit produced.
    always_comb begin
        w_prbs_step = r_prbs;
        w_prbs_word = '0;
        for (int k = 0; k < 8; k++) begin
            w_prbs_word[k] = w_prbs_step[6] ^ w_prbs_step[5];
            w_prbs_step    = {w_prbs_step[5:0], w_prbs_word[k]};
        end
    end

    assign w_train_word = (PATTERN_SEL != 0) ? w_prbs_word : TRAIN_WORD;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prbs_nxt  = r_prbs;
        if (TRAIN_REQ) begin
            w_state_nxt = ST_TRAIN;
            w_cnt_nxt   = '0;
            w_prbs_nxt  = PRBS_SEED;
        end else begin
            case (r_state)
                ST_TRAIN: begin
                    w_prbs_nxt = w_prbs_step;
                    if (r_cnt == TRAIN_LAST && ALIGN_DONE) begin
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt != TRAIN_LAST) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_SYNC: begin
                    if (r_cnt == SYNC_LAST) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    w_state_nxt = ST_DATA;
                end
                default: begin
                    w_state_nxt = ST_TRAIN;
                    w_cnt_nxt   = '0;
                    w_prbs_nxt  = PRBS_SEED;
                end
            endcase
        end
    end

    always_comb begin
        w_data_nxt = {LANES{IDLE_WORD}};
        case (r_state)
            ST_TRAIN: w_data_nxt = {LANES{w_train_word}};
            ST_SYNC:  w_data_nxt = {LANES{SYNC_WORD}};
            ST_DATA:  w_data_nxt = TX_IN_VALID ? TX_IN_DATA
                                               : {LANES{IDLE_WORD}};
            default:  w_data_nxt = {LANES{IDLE_WORD}};
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            r_state    <= ST_TRAIN;
            r_cnt      <= '0;
            r_prbs     <= PRBS_SEED;
            r_tx_data  <= '0;
            r_tx_state <= 2'd0;
            r_training <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prbs     <= w_prbs_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_state <= r_state;
            r_training <= (r_state != ST_DATA);
        end
    end

    // Ready is state-derived so a beat offered with TRAIN_REQ still goes out.
    assign TX_IN_READY = (r_state == ST_DATA) && !TX_SYNC_RST;
    assign TX_DATA     = r_tx_data;
    assign TX_STATE    = r_tx_state;
    assign TRAINING    = r_training;

endmodule

// File: tb/tb_tx_iod_lane_training_gen.sv
// Scoreboard bench for tx_iod_lane_training_gen: fixed-word and PRBS7
// instances share stimulus and are checked against a cycle model.
module tb_tx_iod_lane_training_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        align;
    logic [15:0] din;
    logic        valid;
    logic        rdy0, rdy1;
    logic [15:0] dout0, dout1;
    logic [1:0]  st0, st1;
    logic        tr0, tr1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_iod_lane_training_gen u_fix (
        .FAB_CLK(clk), .TX_SYNC_RST(rst), .TRAIN_REQ(req),
        .ALIGN_DONE(align), .TX_IN_DATA(din), .TX_IN_VALID(valid),
        .TX_IN_READY(rdy0), .TX_DATA(dout0), .TX_STATE(st0),
        .TRAINING(tr0)
    );

    tx_iod_lane_training_gen #(.PATTERN_SEL(1)) u_prbs (
        .FAB_CLK(clk), .TX_SYNC_RST(rst), .TRAIN_REQ(req),
        .ALIGN_DONE(align), .TX_IN_DATA(din), .TX_IN_VALID(valid),
        .TX_IN_READY(rdy1), .TX_DATA(dout1), .TX_STATE(st1),
        .TRAINING(tr1)
    );

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  st;
        logic        tr;
    } exp_t;

    exp_t q[$];

    // PRBS7 reference as a bit stream x[n] = x[n-7] ^ x[n-6], seed all ones.
    bit   pbits[127];
    int   m_state;
    int   m_cnt;
    int   m_widx;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] prbs_word(input int widx);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[j] = pbits[(8 * widx + j) % 127];
        return w;
    endfunction

    task automatic step(input logic i_rst, input logic i_req,
                        input logic i_align, input logic i_valid,
                        input logic [15:0] i_din);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst   = i_rst;
        req   = i_req;
        align = i_align;
        valid = i_valid;
        din   = i_din;
        #1;
        check("ready_fix", 32'(rdy0), 32'(m_state == 2 && !i_rst));
        check("ready_prbs", 32'(rdy1), 32'(m_state == 2 && !i_rst));
        if (i_rst) begin
            e = '{16'h0000, 16'h0000, 2'd0, 1'b1};
            m_state = 0;
            m_cnt   = 0;
            m_widx  = 0;
        end else begin
            e.st = 2'(m_state);
            e.tr = (m_state != 2);
            case (m_state)
                0: begin
                    e.d0 = 16'hF0F0;
                    e.d1 = {2{prbs_word(m_widx)}};
                end
                1: begin
                    e.d0 = 16'hB5B5;
                    e.d1 = 16'hB5B5;
                end
                default: begin
                    e.d0 = i_valid ? i_din : 16'h3C3C;
                    e.d1 = e.d0;
                end
            endcase
            if (i_req) begin
                m_state = 0;
                m_cnt   = 0;
                m_widx  = 0;
            end else if (m_state == 0) begin
                m_widx = (m_widx + 1) % 127;
                if (m_cnt == 255 && i_align) begin
                    m_state = 1;
                    m_cnt   = 0;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
            end else if (m_state == 1) begin
                if (m_cnt == 1) begin
                    m_state = 2;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("data_fix", 32'(dout0), 32'(g.d0));
        check("data_prbs", 32'(dout1), 32'(g.d1));
        check("state_fix", 32'(st0), 32'(g.st));
        check("state_prbs", 32'(st1), 32'(g.st));
        check("training_fix", 32'(tr0), 32'(g.tr));
        check("training_prbs", 32'(tr1), 32'(g.tr));
    endtask

    task automatic idle_n(input int n, input logic i_align);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, i_align, 1'b0, 16'h0);
    endtask

    task automatic run_to(input int st);
        int guard;
        guard = 0;
        while (m_state != st && guard < 2000) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            guard++;
        end
        check("reach_state", 32'(m_state), 32'(st));
    endtask

    initial begin
        bit ext[134];
        int sync_seen;
        int train_seen;
        for (int i = 0; i < 7; i++) ext[i] = 1'b1;
        for (int n = 0; n < 127; n++) begin
            ext[n + 7] = ext[n] ^ ext[n + 1];
            pbits[n]   = ext[n + 7];
        end
        m_state = 0;
        m_cnt   = 0;
        m_widx  = 0;
        rst = 1'b1; req = 1'b0; align = 1'b0; valid = 1'b0; din = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        check("prbs_first_word", 32'(prbs_word(0)), 32'h40);

        // Boundary: count TRAIN / SYNC words seen on the bus.
        train_seen = 0;
        sync_seen  = 0;
        for (int i = 0; i < 262; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            if (dout0 == 16'hF0F0 && st0 == 2'd0) train_seen++;
            if (dout0 == 16'hB5B5) sync_seen++;
        end
        check("train_len", 32'(train_seen), 32'd256);
        check("sync_len", 32'(sync_seen), 32'd2);

        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1122);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h3344);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1122);
        idle_n(2, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)),
                 16'($urandom));

        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hA5C3);
        idle_n(1000, 1'b0);
        run_to(2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h3344);

        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_to(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        idle_n(100, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_to(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h7788);

        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h99AA);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hBBCC);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
